sync_filter: RTL and testbench

SYNC_FILTER -- requirements
Module: sync_filter

---
 rtl/sync_filter.sv | 80 ++++++++
 tb/tb_sync_filter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter.sv
// Multi-channel input conditioner: a plain flip-flop synchronizer per channel,
// followed by a programmable glitch filter with edge pulses and a sticky rise flag.
module sync_filter #(
    parameter int DW     = 1,
    parameter int STAGES = 2,
    parameter int FILT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [FILT_W-1:0] cfg_filt_i,
    input  logic [DW-1:0]     src_i,
    input  logic [DW-1:0]     clr_i,
    output logic [DW-1:0]     dat_o,
    output logic [DW-1:0]     rise_o,
    output logic [DW-1:0]     fall_o,
    output logic [DW-1:0]     stk_o
);

    // A filter length of 0 means the same as 1: accept a change after one sample.
    logic [FILT_W-1:0] thr;
    assign thr = (cfg_filt_i == '0) ? FILT_W'(1) : cfg_filt_i;

    for (genvar gi = 0; gi < DW; gi++) begin : g_ch
        logic [STAGES-1:0] sync_q;
        logic              syn;
        logic [FILT_W-1:0] cnt_q, cnt_d;
        logic [FILT_W:0]   cnt_inc;
        logic              dat_q, dat_d;
        logic              rise_q, rise_d;
        logic              fall_q, fall_d;
        logic              stk_q, stk_d;

        assign syn     = sync_q[STAGES-1];
        assign cnt_inc = {1'b0, cnt_q} + {{FILT_W{1'b0}}, 1'b1};

        always_comb begin
            cnt_d  = cnt_q;
            dat_d  = dat_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (syn == dat_q) begin
                cnt_d = '0;
            end else if (cnt_inc >= {1'b0, thr}) begin
                dat_d  = syn;
                cnt_d  = '0;
                rise_d = syn;
                fall_d = ~syn;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_inc[FILT_W-1:0];
            end
        end

        // Set wins over clear when a rise pulse and a clear request coincide.
        assign stk_d = rise_q | (stk_q & ~clr_i[gi]);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync_q <= '0;
                cnt_q  <= '0;
                dat_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                stk_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[STAGES-2:0], src_i[gi]};
                cnt_q  <= cnt_d;
                dat_q  <= dat_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
                stk_q  <= stk_d;
            end
        end

        assign dat_o[gi]  = dat_q;
        assign rise_o[gi] = rise_q;
        assign fall_o[gi] = fall_q;
        assign stk_o[gi]  = stk_q;
    end

endmodule

// File: tb/tb_sync_filter.sv
// Bench for sync_filter: a directed vector table, hand-written corner sequences and
// a randomized run, all checked cycle by cycle against a behavioural model.
module tb_sync_filter;
    localparam int DW     = 4;
    localparam int STAGES = 2;
    localparam int FILT_W = 8;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [FILT_W-1:0] cfg_filt_i = '0;
    logic [DW-1:0]     src_i = '0;
    logic [DW-1:0]     clr_i = '0;
    logic [DW-1:0]     dat_o, rise_o, fall_o, stk_o;

    sync_filter #(.DW(DW), .STAGES(STAGES), .FILT_W(FILT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .cfg_filt_i (cfg_filt_i),
        .src_i      (src_i),
        .clr_i      (clr_i),
        .dat_o      (dat_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .stk_o      (stk_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the synchronizer is a plain delay line of input samples; the
    // filter accepts the synchronized level once it has disagreed with the output
    // for max(cfg,1) consecutive samples.
    logic [DW-1:0] m_delay [STAGES];
    logic [DW-1:0] m_dat = '0, m_rise = '0, m_fall = '0, m_stk = '0;
    int            m_run [DW];

    task automatic model_step();
        logic [DW-1:0] seen;
        logic [DW-1:0] nrise, nfall;
        int            need;
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) m_delay[s] = '0;
            for (int c = 0; c < DW; c++) m_run[c] = 0;
            m_dat = '0; m_rise = '0; m_fall = '0; m_stk = '0;
        end else begin
            seen  = m_delay[STAGES-1];
            need  = (cfg_filt_i == 0) ? 1 : int'(cfg_filt_i);
            nrise = '0;
            nfall = '0;
            for (int c = 0; c < DW; c++) begin
                if (seen[c] != m_dat[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] >= need) begin
                        m_dat[c]  = seen[c];
                        nrise[c]  = seen[c];
                        nfall[c]  = ~seen[c];
                        m_run[c]  = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_stk  = m_rise | (m_stk & ~clr_i);
            m_rise = nrise;
            m_fall = nfall;
            for (int s = STAGES-1; s > 0; s--) m_delay[s] = m_delay[s-1];
            m_delay[0] = src_i;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_dat",  32'(dat_o),  32'(m_dat));
        chk("model_rise", 32'(rise_o), 32'(m_rise));
        chk("model_fall", 32'(fall_o), 32'(m_fall));
        chk("model_stk",  32'(stk_o),  32'(m_stk));
    endtask

    typedef struct {
        logic          rst;
        logic [7:0]    cfg;
        logic [DW-1:0] src;
        logic [DW-1:0] clr;
        logic [DW-1:0] dat;
        logic [DW-1:0] rise;
        logic [DW-1:0] fall;
        logic [DW-1:0] stk;
    } vec_t;

    vec_t tbl [16];
    int   first, nfall_bits, nrise_bits;
    logic [DW-1:0] fall_vec;

    initial begin
        for (int s = 0; s < STAGES; s++) m_delay[s] = '0;
        for (int c = 0; c < DW; c++) m_run[c] = 0;

        // Channel 0, no filtering: rise after 3 edges, sticky flag, clear, fall,
        // then set and clear coinciding.
        tbl[0]  = '{1'b1, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{1'b1, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 8'd0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 8'd0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{1'b0, 8'd0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
        tbl[5]  = '{1'b0, 8'd0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1};
        tbl[6]  = '{1'b0, 8'd0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[7]  = '{1'b0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[8]  = '{1'b0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[9]  = '{1'b0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[10] = '{1'b0, 8'd1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[11] = '{1'b0, 8'd1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[12] = '{1'b0, 8'd1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
        tbl[13] = '{1'b0, 8'd1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1};
        tbl[14] = '{1'b0, 8'd1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[15] = '{1'b0, 8'd1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rst_i      = tbl[i].rst;
            cfg_filt_i = tbl[i].cfg;
            src_i      = tbl[i].src;
            clr_i      = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_dat", i),  32'(dat_o),  32'(tbl[i].dat));
            chk($sformatf("tbl%0d_rise", i), 32'(rise_o), 32'(tbl[i].rise));
            chk($sformatf("tbl%0d_fall", i), 32'(fall_o), 32'(tbl[i].fall));
            chk($sformatf("tbl%0d_stk", i),  32'(stk_o),  32'(tbl[i].stk));
        end
        clr_i = '0;

        // cfg=5 on channel 1: a 3-cycle glitch is swallowed, a 5-cycle pulse passes.
        cfg_filt_i = 8'd5;
        src_i = '0;
        for (int k = 0; k < 10; k++) step();
        for (int k = 1; k <= 14; k++) begin
            src_i[1] = (k <= 3);
            step();
            chk("glitch_quiet", 32'({dat_o[1], rise_o[1], fall_o[1]}), 32'd0);
        end
        first = 0;
        for (int k = 1; k <= 16; k++) begin
            src_i[1] = (k <= 5);
            step();
            if (rise_o[1] && first == 0) first = k;
        end
        chk("rise_cfg5_latency", 32'(first), 32'd7);
        for (int k = 0; k < 10; k++) step();

        // cfg=4 on channel 2: a one-cycle dropout restarts the count.
        cfg_filt_i = 8'd4;
        first = 0;
        for (int k = 1; k <= 16; k++) begin
            src_i[2] = (k <= 3) || (k >= 5);
            step();
            if (rise_o[2] && first == 0) first = k;
        end
        chk("rise_restart", 32'(first), 32'd10);

        // cfg=8 on channel 3: reset mid-count discards it, src held high rises again.
        cfg_filt_i = 8'd8;
        src_i[3] = 1'b1;
        for (int k = 0; k < 5; k++) step();
        rst_i = 1'b1;
        step();
        chk("rst_all_zero", 32'({dat_o, rise_o, fall_o, stk_o}), 32'd0);
        rst_i = 1'b0;
        first = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (rise_o[3] && first == 0) first = k;
        end
        chk("rise_after_release", 32'(first), 32'd10);

        // All channels fall together.
        cfg_filt_i = 8'd2;
        src_i = '1;
        for (int k = 0; k < 12; k++) step();
        src_i = '0;
        first = 0; nfall_bits = 0; nrise_bits = 0; fall_vec = '0;
        for (int k = 1; k <= 12; k++) begin
            step();
            nfall_bits += $countones(fall_o);
            nrise_bits += $countones(rise_o);
            if (fall_o != '0 && first == 0) begin
                first = k;
                fall_vec = fall_o;
            end
        end
        chk("fall_all_step", 32'(first), 32'd4);
        chk("fall_all_vec", 32'(fall_vec), 32'hF);
        chk("fall_all_count", 32'(nfall_bits), 32'd4);
        chk("fall_all_norise", 32'(nrise_bits), 32'd0);

        // Randomized run including mid-count filter-length changes.
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < DW; c++)
                if ($urandom_range(0, 5) == 0) src_i[c] = ~src_i[c];
            if ($urandom_range(0, 30) == 0) cfg_filt_i = 8'($urandom_range(0, 6));
            clr_i = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
            rst_i = ($urandom_range(0, 300) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
